// File: rtl/video_timing_pkg.sv
// Shared timing constants, axis-total helper and controller state type for the
// Sobel test-path raster generator.
package video_timing_pkg;

  localparam int   DEF_H_ACTIVE = 64;
  localparam int   DEF_H_FP     = 4;
  localparam int   DEF_H_SYNC   = 8;
  localparam int   DEF_H_BP     = 4;
  localparam int   DEF_V_ACTIVE = 64;
  localparam int   DEF_V_FP     = 2;
  localparam int   DEF_V_SYNC   = 2;
  localparam int   DEF_V_BP     = 4;
  localparam logic DEF_SYNC_POL = 1'b0;
  localparam int   DEF_CNT_W    = 7;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } vt_state_e;

  function automatic int axis_total(input int act, input int fp, input int sync, input int bp);
    return act + fp + sync + bp;
  endfunction

  function automatic int sync_lo(input int act, input int fp);
    return act + fp;
  endfunction

  function automatic int sync_hi(input int act, input int fp, input int sync);
    return act + fp + sync;
  endfunction

endpackage

// File: rtl/video_timing_ctrl_axis.sv
// One raster axis: holds the count, exposes the next count's decode so the
// controller can register every output in step with the counter itself.
module timing_axis_counter
  import video_timing_pkg::*;
#(
  parameter int CNT_W   = DEF_CNT_W,
  parameter int TOTAL   = 80,
  parameter int ACTIVE  = 64,
  parameter int SYNC_LO = 68,
  parameter int SYNC_HI = 76
)(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic             i_adv,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_last,
  output logic             o_nxt_first,
  output logic             o_nxt_last,
  output logic             o_nxt_act,
  output logic             o_nxt_sync
);

  // Window bounds are compared one bit wider so a bound equal to 2^CNT_W still works.
  localparam int               EXT_W   = CNT_W + 1;
  localparam logic [CNT_W-1:0] C_LAST  = CNT_W'(TOTAL - 1);
  localparam logic [EXT_W-1:0] C_ACT   = EXT_W'(ACTIVE);
  localparam logic [EXT_W-1:0] C_S_LO  = EXT_W'(SYNC_LO);
  localparam logic [EXT_W-1:0] C_S_HI  = EXT_W'(SYNC_HI);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_nxt;
  logic [EXT_W-1:0] w_nxt_ext;

  assign o_last = (r_cnt == C_LAST);

  always_comb begin
    w_nxt = r_cnt;
    if (i_clr) begin
      w_nxt = '0;
    end else if (i_adv) begin
      w_nxt = o_last ? '0 : r_cnt + CNT_W'(1);
    end
  end

  assign w_nxt_ext   = {1'b0, w_nxt};
  assign o_nxt_first = (w_nxt == '0);
  assign o_nxt_last  = (w_nxt == C_LAST);
  assign o_nxt_act   = (w_nxt_ext < C_ACT);
  assign o_nxt_sync  = (w_nxt_ext >= C_S_LO) && (w_nxt_ext < C_S_HI);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_nxt;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/video_timing_ctrl.sv
// Raster timing controller: frames start and stop only on frame boundaries,
// all outputs registered from the next h/v so they agree within each cycle.
module video_timing_ctrl
  import video_timing_pkg::*;
#(
  parameter int   H_ACTIVE = DEF_H_ACTIVE,
  parameter int   H_FP     = DEF_H_FP,
  parameter int   H_SYNC   = DEF_H_SYNC,
  parameter int   H_BP     = DEF_H_BP,
  parameter int   V_ACTIVE = DEF_V_ACTIVE,
  parameter int   V_FP     = DEF_V_FP,
  parameter int   V_SYNC   = DEF_V_SYNC,
  parameter int   V_BP     = DEF_V_BP,
  parameter logic SYNC_POL = DEF_SYNC_POL,
  parameter int   CNT_W    = DEF_CNT_W
)(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  output logic             active,
  output logic             hsync,
  output logic             vsync,
  output logic             frame_start,
  output logic             line_start,
  output logic             frame_done,
  output logic [CNT_W-1:0] x,
  output logic [CNT_W-1:0] y,
  output logic             running
);

  localparam int H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  vt_state_e r_state;
  logic      r_active, r_hsync, r_vsync, r_frame_start, r_line_start, r_frame_done, r_running;

  logic w_run, w_nxt_run, w_frame_end;
  logic w_h_last, w_h_nxt_first, w_h_nxt_last, w_h_nxt_act, w_h_nxt_sync;
  logic w_v_last, w_v_nxt_first, w_v_nxt_last, w_v_nxt_act, w_v_nxt_sync;
  logic [CNT_W-1:0] w_h_cnt, w_v_cnt;

  assign w_run       = (r_state == RUN);
  assign w_frame_end = w_run && w_h_last && w_v_last;

  // Leaving RUN is only possible at the frame end, so enable is ignored mid-frame.
  always_comb begin
    w_nxt_run = 1'b0;
    case (r_state)
      IDLE:    w_nxt_run = enable;
      RUN:     w_nxt_run = !w_frame_end || enable;
      default: w_nxt_run = 1'b0;
    endcase
  end

  timing_axis_counter #(
    .CNT_W   (CNT_W),
    .TOTAL   (H_TOTAL),
    .ACTIVE  (H_ACTIVE),
    .SYNC_LO (sync_lo(H_ACTIVE, H_FP)),
    .SYNC_HI (sync_hi(H_ACTIVE, H_FP, H_SYNC))
  ) u_h_axis (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_clr       (!w_nxt_run),
    .i_adv       (w_run),
    .o_cnt       (w_h_cnt),
    .o_last      (w_h_last),
    .o_nxt_first (w_h_nxt_first),
    .o_nxt_last  (w_h_nxt_last),
    .o_nxt_act   (w_h_nxt_act),
    .o_nxt_sync  (w_h_nxt_sync)
  );

  timing_axis_counter #(
    .CNT_W   (CNT_W),
    .TOTAL   (V_TOTAL),
    .ACTIVE  (V_ACTIVE),
    .SYNC_LO (sync_lo(V_ACTIVE, V_FP)),
    .SYNC_HI (sync_hi(V_ACTIVE, V_FP, V_SYNC))
  ) u_v_axis (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_clr       (!w_nxt_run),
    .i_adv       (w_run && w_h_last),
    .o_cnt       (w_v_cnt),
    .o_last      (w_v_last),
    .o_nxt_first (w_v_nxt_first),
    .o_nxt_last  (w_v_nxt_last),
    .o_nxt_act   (w_v_nxt_act),
    .o_nxt_sync  (w_v_nxt_sync)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_running     <= 1'b0;
      r_active      <= 1'b0;
      r_hsync       <= ~SYNC_POL;
      r_vsync       <= ~SYNC_POL;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
      r_frame_done  <= 1'b0;
    end else begin
      r_state       <= w_nxt_run ? RUN : IDLE;
      r_running     <= w_nxt_run;
      r_active      <= w_nxt_run && w_h_nxt_act && w_v_nxt_act;
      r_hsync       <= (w_nxt_run && w_h_nxt_sync) ? SYNC_POL : ~SYNC_POL;
      r_vsync       <= (w_nxt_run && w_v_nxt_sync) ? SYNC_POL : ~SYNC_POL;
      r_line_start  <= w_nxt_run && w_h_nxt_first;
      r_frame_start <= w_nxt_run && w_h_nxt_first && w_v_nxt_first;
      r_frame_done  <= w_nxt_run && w_h_nxt_last && w_v_nxt_last;
    end
  end

  assign active      = r_active;
  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign frame_start = r_frame_start;
  assign line_start  = r_line_start;
  assign frame_done  = r_frame_done;
  assign running     = r_running;
  assign x           = w_h_cnt;
  assign y           = w_v_cnt;

endmodule

// File: tb/tb_video_timing_ctrl.sv
// Bench for video_timing_ctrl: a frame-position model (p in 0..frame-1) predicts
// every output each cycle under randomized enable activity.
module tb_video_timing_ctrl;

  localparam int HA = 64, HFP = 4, HS = 8, HBP = 4;
  localparam int VA = 64, VFP = 2, VS = 2, VBP = 4;
  localparam int HT = HA + HFP + HS + HBP;
  localparam int VT = VA + VFP + VS + VBP;
  localparam int FRAME = HT * VT;
  localparam logic [20:0] RST_VAL = {1'b0, 1'b0, 1'b1, 1'b1, 3'b000, 14'd0};

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic       active, hsync, vsync, frame_start, line_start, frame_done, running;
  logic [6:0] x, y;

  int n_chk  = 0;
  int n_fail = 0;
  bit m_run  = 1'b0;
  int m_p    = 0;

  always #5 clk = ~clk;

  video_timing_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .active      (active),
    .hsync       (hsync),
    .vsync       (vsync),
    .frame_start (frame_start),
    .line_start  (line_start),
    .frame_done  (frame_done),
    .x           (x),
    .y           (y),
    .running     (running)
  );

  wire [20:0] w_obs = {running, active, hsync, vsync, frame_start, line_start, frame_done, x, y};

  // Drive enable for the coming edge, advance the frame-position model, sample #1 later.
  task automatic tick(input logic en);
    enable = en;
    @(posedge clk);
    if (!rst_n) begin
      m_run = 1'b0;
      m_p   = 0;
    end else if (!m_run) begin
      if (en) begin
        m_run = 1'b1;
        m_p   = 0;
      end
    end else if (m_p == FRAME - 1) begin
      if (!en) m_run = 1'b0;
      m_p = 0;
    end else begin
      m_p++;
    end
    #1;
  endtask

  function automatic logic [20:0] exp_out();
    int h, v;
    logic act, hs, vs;
    h = m_p % HT;
    v = m_p / HT;
    if (!m_run) return RST_VAL;
    act = (h < HA) && (v < VA);
    hs  = !((h >= HA + HFP) && (h < HA + HFP + HS));
    vs  = !((v >= VA + VFP) && (v < VA + VFP + VS));
    return {1'b1, act, hs, vs, (m_p == 0), (h == 0), (m_p == FRAME - 1), 7'(h), 7'(v)};
  endfunction

  task automatic test_reset();
    rst_n  = 1'b0;
    enable = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_chk++;
    if (w_obs !== RST_VAL) begin
      n_fail++;
      $display("FAIL reset_hold obs=%h exp=%h", w_obs, RST_VAL);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick(1'b0);
      n_chk++;
      if (w_obs !== exp_out()) begin
        n_fail++;
        $display("FAIL reset_idle cyc=%0d obs=%h exp=%h", i, w_obs, exp_out());
      end
    end
    n_chk++;
    if ({hsync, vsync, x, y} !== {1'b1, 1'b1, 7'd0, 7'd0}) begin
      n_fail++;
      $display("FAIL reset_sync_xy hs=%b vs=%b x=%0d y=%0d exp 1 1 0 0", hsync, vsync, x, y);
    end
  endtask

  task automatic test_full_frame();
    int n_act, n_ls, n_vs_lo, n_hs_l0;
    n_act = 0; n_ls = 0; n_vs_lo = 0; n_hs_l0 = 0;
    tick(1'b1);
    n_chk++;
    if ({running, frame_start, line_start, active, x, y} !== {4'b1111, 14'd0}) begin
      n_fail++;
      $display("FAIL start_first_cycle run=%b fs=%b ls=%b act=%b x=%0d y=%0d exp 1 1 1 1 0 0",
               running, frame_start, line_start, active, x, y);
    end
    for (int c = 0; c < FRAME; c++) begin
      n_chk++;
      if (w_obs !== exp_out()) begin
        n_fail++;
        $display("FAIL frame_cycle p=%0d obs=%h exp=%h", c, w_obs, exp_out());
      end
      n_act   += int'(active);
      n_ls    += int'(line_start);
      n_vs_lo += int'(!vsync);
      if (y == 7'd0 && !hsync) n_hs_l0++;
      if (c == HT) begin
        n_chk++;
        if ({line_start, x, y} !== {1'b1, 7'd0, 7'd1}) begin
          n_fail++;
          $display("FAIL line1_start ls=%b x=%0d y=%0d exp 1 0 1", line_start, x, y);
        end
      end
      if (c == FRAME - 1) begin
        n_chk++;
        if ({frame_done, x, y} !== {1'b1, 7'(HT - 1), 7'(VT - 1)}) begin
          n_fail++;
          $display("FAIL frame_done_pos fd=%b x=%0d y=%0d exp 1 %0d %0d", frame_done, x, y, HT - 1, VT - 1);
        end
      end
      if (c < FRAME - 1) tick(1'($urandom_range(0, 1)));
    end
    n_chk++;
    if (n_act != HA * VA) begin
      n_fail++;
      $display("FAIL active_count got=%0d exp=%0d", n_act, HA * VA);
    end
    n_chk++;
    if (n_ls != VT) begin
      n_fail++;
      $display("FAIL line_start_count got=%0d exp=%0d", n_ls, VT);
    end
    n_chk++;
    if (n_vs_lo != VS * HT) begin
      n_fail++;
      $display("FAIL vsync_low_count got=%0d exp=%0d", n_vs_lo, VS * HT);
    end
    n_chk++;
    if (n_hs_l0 != HS) begin
      n_fail++;
      $display("FAIL hsync_line0_count got=%0d exp=%0d", n_hs_l0, HS);
    end
    tick(1'b1);
    n_chk++;
    if ({running, frame_start, x, y} !== {2'b11, 14'd0}) begin
      n_fail++;
      $display("FAIL continuous_restart run=%b fs=%b x=%0d y=%0d exp 1 1 0 0", running, frame_start, x, y);
    end
  endtask

  task automatic test_drop_enable();
    int n_fd, idle_cyc;
    n_fd = 0; idle_cyc = 0;
    for (int g = 0; g < FRAME && m_p != 30 * HT + 10; g++) begin
      tick(1'b1);
      n_chk++;
      if (w_obs !== exp_out()) begin
        n_fail++;
        $display("FAIL drop_pre p=%0d obs=%h exp=%h", m_p, w_obs, exp_out());
      end
    end
    for (int g = 0; g < FRAME + 20 && idle_cyc < 10; g++) begin
      tick(1'b0);
      n_chk++;
      if (w_obs !== exp_out()) begin
        n_fail++;
        $display("FAIL drop_post p=%0d run=%0d obs=%h exp=%h", m_p, m_run, w_obs, exp_out());
      end
      n_fd += int'(frame_done);
      if (!m_run) idle_cyc++;
    end
    n_chk++;
    if (n_fd != 1) begin
      n_fail++;
      $display("FAIL drop_frame_done_count got=%0d exp=1", n_fd);
    end
    n_chk++;
    if ({running, x, y} !== 15'd0) begin
      n_fail++;
      $display("FAIL drop_idle run=%b x=%0d y=%0d exp 0 0 0", running, x, y);
    end
  endtask

  task automatic test_back_to_back();
    int drop_at, raise_at;
    drop_at  = $urandom_range(100, 2000);
    raise_at = $urandom_range(2001, FRAME - 2);
    tick(1'b1);
    n_chk++;
    if (frame_start !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_start fs=%b exp 1", frame_start);
    end
    for (int g = 0; g < FRAME && m_p != FRAME - 1; g++) begin
      tick((m_p >= drop_at && m_p < raise_at) ? 1'b0 : 1'b1);
      n_chk++;
      if (w_obs !== exp_out()) begin
        n_fail++;
        $display("FAIL b2b_cycle p=%0d obs=%h exp=%h", m_p, w_obs, exp_out());
      end
    end
    n_chk++;
    if (frame_done !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_frame_done fd=%b exp 1", frame_done);
    end
    tick(1'b1);
    n_chk++;
    if ({running, frame_start, x, y} !== {2'b11, 14'd0}) begin
      n_fail++;
      $display("FAIL b2b_seamless run=%b fs=%b x=%0d y=%0d exp 1 1 0 0", running, frame_start, x, y);
    end
  endtask

  task automatic test_reset_mid_frame();
    for (int g = 0; g < FRAME && m_p != 20 * HT + 40; g++) tick(1'b1);
    #2 rst_n = 1'b0;
    #1;
    n_chk++;
    if (w_obs !== RST_VAL) begin
      n_fail++;
      $display("FAIL async_clear obs=%h exp=%h", w_obs, RST_VAL);
    end
    m_run = 1'b0;
    m_p   = 0;
    for (int i = 0; i < 2; i++) begin
      tick(1'b1);
      n_chk++;
      if (w_obs !== exp_out()) begin
        n_fail++;
        $display("FAIL reset_held obs=%h exp=%h", w_obs, exp_out());
      end
    end
    rst_n = 1'b1;
    tick(1'b1);
    n_chk++;
    if ({running, frame_start, active, x, y} !== {3'b111, 14'd0}) begin
      n_fail++;
      $display("FAIL restart_after_reset run=%b fs=%b act=%b x=%0d y=%0d exp 1 1 1 0 0",
               running, frame_start, active, x, y);
    end
    for (int i = 0; i < 200; i++) begin
      tick(1'($urandom_range(0, 1)));
      n_chk++;
      if (w_obs !== exp_out()) begin
        n_fail++;
        $display("FAIL post_reset_run p=%0d obs=%h exp=%h", m_p, w_obs, exp_out());
      end
    end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_drop_enable();
    test_back_to_back();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
